// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Receives a short program over a valid/ready stream, stores it in a small
//   word memory, verifies a trailing XOR checksum word and releases the
//   processor core only after a load whose checksum matches.
//
// Ports
//   clk         rising-edge clock, the only clock of the block
//   reset       asynchronous active-high reset
//   clk_en      state-advance enable; all registers hold while 0
//   load_start  begin (or restart) a program load
//   in_valid    loader-side word valid
//   in_data     instruction word or checksum word
//   in_ready    block accepts in_data this cycle (LOAD or CHECK)
//   rd_addr     processor program-counter address
//   rd_data     instruction at rd_addr (combinational, 00 when out of range)
//   core_hold   holds the processor in reset until a good load completes
//   loading     load in progress (LOAD or CHECK)
//   done        last load completed with a matching checksum
//   error       last load completed with a mismatching checksum
//   word_count  number of words written in the current load
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int unsigned WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic       load_start,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    output logic       in_ready,
    input  logic [1:0] rd_addr,
    output logic [1:0] rd_data,
    output logic       core_hold,
    output logic       loading,
    output logic       done,
    output logic       error,
    output logic [2:0] word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam logic [1:0] LAST_PTR = 2'(WORDS - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] cksum_q, cksum_d;
    logic [2:0] count_q, count_d;
    logic       wr_en;

    // Program storage, one 2-bit slice per word.
    logic [2*WORDS-1:0] mem_flat;

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            cksum_q <= 2'd0;
            count_q <= 3'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cksum_q <= cksum_d;
            count_q <= count_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. Every _d defaults to its _q so clk_en=0 holds all state.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cksum_d = cksum_q;
        count_d = count_q;
        wr_en   = 1'b0;

        if (clk_en) begin
            if (load_start) begin
                // Restart wins over any transfer presented on the same edge.
                state_d = LOAD;
                ptr_d   = 2'd0;
                cksum_d = 2'd0;
                count_d = 3'd0;
            end else begin
                unique case (state_q)
                    LOAD: begin
                        if (in_valid) begin
                            wr_en   = 1'b1;
                            cksum_d = cksum_q ^ in_data;
                            count_d = count_q + 3'd1;
                            // Pointer saturates at the last entry; the move to
                            // CHECK stops any further writes anyway.
                            if (ptr_q != LAST_PTR) begin
                                ptr_d = ptr_q + 2'd1;
                            end
                            if (ptr_q == LAST_PTR) begin
                                state_d = CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        if (in_valid) begin
                            state_d = (in_data == cksum_q) ? DONE : ERROR;
                        end
                    end
                    default: begin
                        // IDLE, DONE, ERROR: only load_start leaves them.
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Word storage: write port driven by the FSM, cleared by reset.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_mem
            logic [1:0] word_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_q <= 2'd0;
                end else if (wr_en && (ptr_q == 2'(gi))) begin
                    word_q <= in_data;
                end
            end

            assign mem_flat[2*gi +: 2] = word_q;
        end
    endgenerate

    // Combinational read port; addresses beyond the stored program read 00.
    always_comb begin
        rd_data = 2'd0;
        for (int i = 0; i < WORDS; i++) begin
            if (rd_addr == 2'(i)) begin
                rd_data = mem_flat[2*i +: 2];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status outputs, decoded from registered state only.
    // -------------------------------------------------------------------------
    assign in_ready   = (state_q == LOAD) || (state_q == CHECK);
    assign loading    = in_ready;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERROR);
    assign core_hold  = (state_q != DONE);
    assign word_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Self-checking bench for program_loader. Words sent during a load are
//   pushed to an expected-memory queue and popped when the program is read
//   back through rd_addr/rd_data. A second instance covers WORDS=2.
// -----------------------------------------------------------------------------
module tb_program_loader;

    logic       clk;
    logic       reset;

    // Instance A (WORDS=4)
    logic       clk_en, load_start, in_valid;
    logic [1:0] in_data, rd_addr;
    logic       in_ready, core_hold, loading, done, error;
    logic [1:0] rd_data;
    logic [2:0] word_count;

    // Instance B (WORDS=2)
    logic       b_clk_en, b_load_start, b_in_valid;
    logic [1:0] b_in_data, b_rd_addr;
    logic       b_in_ready, b_core_hold, b_loading, b_done, b_error;
    logic [1:0] b_rd_data;
    logic [2:0] b_word_count;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];
    int         cnt_m;

    program_loader #(.WORDS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (clk_en),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .core_hold  (core_hold),
        .loading    (loading),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    program_loader #(.WORDS(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .clk_en     (b_clk_en),
        .load_start (b_load_start),
        .in_valid   (b_in_valid),
        .in_data    (b_in_data),
        .in_ready   (b_in_ready),
        .rd_addr    (b_rd_addr),
        .rd_data    (b_rd_data),
        .core_hold  (b_core_hold),
        .loading    (b_loading),
        .done       (b_done),
        .error      (b_error),
        .word_count (b_word_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status vector {loading, in_ready, done, error, core_hold}
    task automatic check_status(input string tag, input logic [4:0] exp);
        check_val(tag, {3'b000, loading, in_ready, done, error, core_hold}, {3'b000, exp});
    endtask

    task automatic do_start();
        load_start = 1'b1;
        clk_en     = 1'b1;
        tick();
        load_start = 1'b0;
        exp_q.delete();
        cnt_m = 0;
        check_status("start_status", 5'b11001);
        check_val("start_count", {5'b0, word_count}, 8'd0);
    endtask

    // Send one instruction word; with stall=1 the first cycle has clk_en=0.
    task automatic send_word(input logic [1:0] d, input bit stall);
        in_valid = 1'b1;
        in_data  = d;
        if (stall) begin
            clk_en = 1'b0;
            tick();
            check_val("stall_count", {5'b0, word_count}, 8'(cnt_m));
            check_val("stall_ready", {7'b0, in_ready}, 8'd1);
            clk_en = 1'b1;
        end
        tick();
        in_valid = 1'b0;
        exp_q.push_back(d);
        cnt_m++;
        check_val("word_count", {5'b0, word_count}, 8'(cnt_m));
    endtask

    task automatic send_cksum(input logic [1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic readback(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 2'(i);
            #1;
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 8'd1, 8'd0);
            end else begin
                check_val($sformatf("rd_data[%0d]", i), {6'b0, rd_data}, {6'b0, exp_q.pop_front()});
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clk_en = 1'b0; load_start = 1'b0; in_valid = 1'b0; in_data = 2'd0; rd_addr = 2'd0;
        b_clk_en = 1'b0; b_load_start = 1'b0; b_in_valid = 1'b0; b_in_data = 2'd0; b_rd_addr = 2'd0;
        cnt_m = 0;

        // Reset state
        #2;
        check_status("reset_status", 5'b00001);
        check_val("reset_count", {5'b0, word_count}, 8'd0);
        #10;
        reset = 1'b0;
        tick();
        check_status("idle_after_reset", 5'b00001);

        // Good load
        do_start();
        send_word(2'b01, 1'b0);
        send_word(2'b10, 1'b0);
        send_word(2'b11, 1'b0);
        check_status("still_load", 5'b11001);
        send_word(2'b00, 1'b0);
        check_status("in_check", 5'b11001);
        send_cksum(2'b00);
        check_status("good_done", 5'b00100);
        // in_valid ignored in DONE
        in_valid = 1'b1; in_data = 2'b11;
        tick();
        in_valid = 1'b0;
        check_status("done_hold", 5'b00100);
        readback(4);

        // Bad checksum
        do_start();
        send_word(2'b01, 1'b0);
        send_word(2'b10, 1'b0);
        send_word(2'b11, 1'b0);
        send_word(2'b00, 1'b0);
        send_cksum(2'b01);
        check_status("bad_error", 5'b00011);
        readback(4);

        // Stalls: alternate clk_en plus 3 idle in_valid cycles mid-load
        do_start();
        send_word(2'b01, 1'b1);
        send_word(2'b10, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("gap_count", {5'b0, word_count}, 8'(cnt_m));
        end
        send_word(2'b11, 1'b1);
        send_word(2'b00, 1'b1);
        send_cksum(2'b00);
        check_status("stall_done", 5'b00100);
        readback(4);

        // Restart mid-load
        do_start();
        send_word(2'b11, 1'b0);
        send_word(2'b11, 1'b0);
        do_start();
        send_word(2'b10, 1'b0);
        send_word(2'b01, 1'b0);
        send_word(2'b00, 1'b0);
        send_word(2'b01, 1'b0);
        send_cksum(2'b10);
        check_status("restart_done", 5'b00100);
        readback(4);

        // Asynchronous reset after 3 words
        do_start();
        send_word(2'b01, 1'b0);
        send_word(2'b10, 1'b0);
        send_word(2'b11, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_status("async_reset_status", 5'b00001);
        check_val("async_reset_count", {5'b0, word_count}, 8'd0);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
        readback(4);
        reset = 1'b0;
        in_valid = 1'b1; in_data = 2'b11;
        tick();
        tick();
        in_valid = 1'b0;
        check_status("idle_ignores_valid", 5'b00001);
        check_val("idle_count", {5'b0, word_count}, 8'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(2'b00);
        readback(4);
        // load_start without clk_en must not start a load
        load_start = 1'b1; clk_en = 1'b0;
        tick();
        load_start = 1'b0; clk_en = 1'b1;
        check_status("start_gated", 5'b00001);

        // WORDS=2 instance
        b_load_start = 1'b1; b_clk_en = 1'b1;
        tick();
        b_load_start = 1'b0;
        exp_q.delete();
        b_in_valid = 1'b1; b_in_data = 2'b10;
        tick();
        exp_q.push_back(2'b10);
        check_val("b_count1", {5'b0, b_word_count}, 8'd1);
        b_in_data = 2'b01;
        tick();
        exp_q.push_back(2'b01);
        check_val("b_count2", {5'b0, b_word_count}, 8'd2);
        check_val("b_in_check", {6'b0, b_loading, b_done}, 8'b10);
        b_in_data = 2'b11;
        tick();
        b_in_valid = 1'b0;
        check_val("b_done", {5'b0, b_done, b_error, b_core_hold}, 8'b100);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        for (int i = 0; i < 4; i++) begin
            b_rd_addr = 2'(i);
            #1;
            check_val($sformatf("b_rd_data[%0d]", i), {6'b0, b_rd_data}, {6'b0, exp_q.pop_front()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
